maxmin_band_tracker: RTL and testbench

Streaming band generator. It accepts a stream of unsigned samples and tracks the minimum and maximum over fixed windows of `WIN` accepted samples. At the close of each window it publishes the band as an `amax`/`amin` pair through a valid/ready output. It sits upstream of the max/min band comparator and produces the `amax`/`amin` bounds that the comparator consumes.

---
 rtl/maxmin_band_pkg.sv | 19 +
 rtl/maxmin_band_acc.sv | 74 +++++++
 rtl/maxmin_band_tracker.sv | 126 ++++++++++++
 tb/tb_maxmin_band_tracker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxmin_band_pkg.sv
// Shared types and sizing helpers for the max/min band tracker.
package maxmin_band_pkg;

  typedef enum logic [0:0] {
    ACC   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam int unsigned DEF_W   = 8;
  localparam int unsigned DEF_WIN = 16;

  // Counter width for a window of win samples; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned win);
    int unsigned w;
    w = $clog2(win);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/maxmin_band_acc.sv
// Window max/min accumulator and accept counter; close_o pulses on the accept
// that completes a window, with band_*_o already including that sample.
module maxmin_band_acc
  import maxmin_band_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned WIN = DEF_WIN,
  parameter int unsigned CW  = cnt_width(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          accept_i,
  input  logic          first_i,
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o,
  output logic [W-1:0]  win_max_o,
  output logic [W-1:0]  win_min_o,
  output logic [W-1:0]  band_max_o,
  output logic [W-1:0]  band_min_o,
  output logic          close_o
);

  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  max_q, max_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  nmax, nmin;

  always_comb begin
    if (first_i) begin
      nmax = data_i;
      nmin = data_i;
    end else begin
      nmax = (data_i > max_q) ? data_i : max_q;
      nmin = (data_i < min_q) ? data_i : min_q;
    end
  end

  assign close_o = accept_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    min_d = min_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (accept_i) begin
      cnt_d = close_o ? '0 : cnt_q + 1'b1;
      max_d = nmax;
      min_d = nmin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      max_q <= '0;
      min_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign win_max_o  = max_q;
  assign win_min_o  = min_q;
  assign band_max_o = nmax;
  assign band_min_o = nmin;

endmodule

// File: rtl/maxmin_band_tracker.sv
// Streaming max/min band generator: FSM, output register and optional sticky
// merge (enabled by defining MAXMIN_BAND_STICKY_EN).
module maxmin_band_tracker
  import maxmin_band_pkg::*;
#(
  parameter int unsigned W   = DEF_W,
  parameter int unsigned WIN = DEF_WIN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         band_valid,
  input  logic         band_ready,
  output logic [W-1:0] amax,
  output logic [W-1:0] amin
);

  localparam int unsigned CW = cnt_width(WIN);
  localparam logic [0:0] ST_ACC   = ACC;
  localparam logic [0:0] ST_STALL = STALL;

  logic [0:0]    state_q, state_d;
  logic          bv_q, bv_d;
  logic [W-1:0]  amax_q, amax_d;
  logic [W-1:0]  amin_q, amin_d;

  logic          accept, pop, first, close;
  logic [CW-1:0] acc_cnt;
  logic [W-1:0]  held_max, held_min, band_max, band_min;
  logic          load;
  logic [W-1:0]  load_max, load_min, merged_max, merged_min;

  assign in_ready = (state_q == ST_ACC);
  assign accept   = in_valid && in_ready && !clr;
  assign pop      = bv_q && band_ready;
  assign first    = (acc_cnt == '0);

  maxmin_band_acc #(
    .W   (W),
    .WIN (WIN),
    .CW  (CW)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .accept_i   (accept),
    .first_i    (first),
    .data_i     (in_data),
    .cnt_o      (acc_cnt),
    .win_max_o  (held_max),
    .win_min_o  (held_min),
    .band_max_o (band_max),
    .band_min_o (band_min),
    .close_o    (close)
  );

`ifdef MAXMIN_BAND_STICKY_EN
  // Remembers whether a band has been published since reset or clr.
  logic seen_q, seen_d;

  always_comb begin
    merged_max = (seen_q && amax_q > load_max) ? amax_q : load_max;
    merged_min = (seen_q && amin_q < load_min) ? amin_q : load_min;
    seen_d     = clr ? 1'b0 : (seen_q || load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_q <= 1'b0;
    else        seen_q <= seen_d;
  end
`else
  assign merged_max = load_max;
  assign merged_min = load_min;
`endif

  always_comb begin
    state_d  = state_q;
    bv_d     = bv_q;
    load     = 1'b0;
    load_max = band_max;
    load_min = band_min;
    if (clr) begin
      state_d = ST_ACC;
      bv_d    = 1'b0;
    end else begin
      if (pop) bv_d = 1'b0;
      if (state_q == ST_STALL && pop) begin
        load     = 1'b1;
        load_max = held_max;
        load_min = held_min;
        state_d  = ST_ACC;
      end else if (close) begin
        if (!bv_q || pop) load = 1'b1;
        else              state_d = ST_STALL;
      end
      if (load) bv_d = 1'b1;
    end
  end

  always_comb begin
    amax_d = load ? merged_max : amax_q;
    amin_d = load ? merged_min : amin_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      bv_q    <= 1'b0;
      amax_q  <= '0;
      amin_q  <= '0;
    end else begin
      state_q <= state_d;
      bv_q    <= bv_d;
      amax_q  <= amax_d;
      amin_q  <= amin_d;
    end
  end

  assign band_valid = bv_q;
  assign amax       = amax_q;
  assign amin       = amin_q;

endmodule

// File: tb/tb_maxmin_band_tracker.sv
// Self-checking bench: WIN=4 and WIN=1 instances share stimulus and are compared
// every cycle against a behavioural window model, plus literal checks.
module tb_maxmin_band_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       band_ready = 1'b0;

  logic       in_ready4, bv4, in_ready1, bv1;
  logic [7:0] amax4, amin4, amax1, amin1;

  int errors = 0;
  int checks = 0;
  int nbands, lastmax, lastmin;

  always #5 clk = ~clk;

  maxmin_band_tracker #(.W(8), .WIN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .band_valid(bv4), .band_ready(band_ready), .amax(amax4), .amin(amin4)
  );

  maxmin_band_tracker #(.W(8), .WIN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .band_valid(bv1), .band_ready(band_ready), .amax(amax1), .amin(amin1)
  );

  // ---------------- behavioural model (index 0: WIN=4, index 1: WIN=1) -------
  int wins [2] = '{4, 1};
  int m_samples [2][$];
  int m_stall [2], m_hmax [2], m_hmin [2];
  int m_bv [2], m_amax [2], m_amin [2], m_seen [2];

  function automatic int qmax(input int q[$]);
    int r = q[0];
    foreach (q[k]) if (q[k] > r) r = q[k];
    return r;
  endfunction

  function automatic int qmin(input int q[$]);
    int r = q[0];
    foreach (q[k]) if (q[k] < r) r = q[k];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int pmax, pmin;
    bit pop, pub, bv0;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_samples[i].delete();
        m_stall[i] = 0; m_bv[i] = 0; m_amax[i] = 0; m_amin[i] = 0; m_seen[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          m_samples[i].delete();
          m_stall[i] = 0; m_bv[i] = 0; m_seen[i] = 0;
        end else begin
          bv0 = (m_bv[i] != 0);
          pop = bv0 && band_ready;
          pub = 0;
          pmax = 0; pmin = 0;
          if (pop) m_bv[i] = 0;
          if (m_stall[i] != 0 && pop) begin
            pub = 1; pmax = m_hmax[i]; pmin = m_hmin[i]; m_stall[i] = 0;
          end else if (in_valid && m_stall[i] == 0) begin
            m_samples[i].push_back(int'(in_data));
            if (m_samples[i].size() == wins[i]) begin
              pmax = qmax(m_samples[i]);
              pmin = qmin(m_samples[i]);
              m_samples[i].delete();
              if (!bv0 || pop) pub = 1;
              else begin
                m_stall[i] = 1; m_hmax[i] = pmax; m_hmin[i] = pmin;
              end
            end
          end
          if (pub) begin
`ifdef MAXMIN_BAND_STICKY_EN
            if (m_seen[i] != 0) begin
              if (m_amax[i] > pmax) pmax = m_amax[i];
              if (m_amin[i] < pmin) pmin = m_amin[i];
            end
`endif
            m_amax[i] = pmax; m_amin[i] = pmin; m_bv[i] = 1; m_seen[i] = 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare process ---------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("model_bv4", int'(bv4), m_bv[0]);
      cmp("model_rdy4", int'(in_ready4), (m_stall[0] == 0) ? 1 : 0);
      cmp("model_amax4", int'(amax4), m_amax[0]);
      cmp("model_amin4", int'(amin4), m_amin[0]);
      cmp("model_bv1", int'(bv1), m_bv[1]);
      cmp("model_rdy1", int'(in_ready1), (m_stall[1] == 0) ? 1 : 0);
      cmp("model_amax1", int'(amax1), m_amax[1]);
      cmp("model_amin1", int'(amin1), m_amin[1]);
    end
  end

  // ---------------- stimulus --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bv4) begin
      nbands++; lastmax = int'(amax4); lastmin = int'(amin4);
    end
  endtask

  task automatic feed(input int d);
    in_valid = 1'b1;
    in_data = 8'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    cmp({tag, "_bv"}, int'(bv4), 0);
    cmp({tag, "_amax"}, int'(amax4), 0);
    cmp({tag, "_amin"}, int'(amin4), 0);
    cmp({tag, "_rdy"}, int'(in_ready4), 1);
    cmp({tag, "_bv1"}, int'(bv1), 0);
    cmp({tag, "_rdy1"}, int'(in_ready1), 1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window, consumer always ready.
    band_ready = 1'b1;
    feed(50); feed(200); feed(100); feed(150);
    cmp("basic_bv", int'(bv4), 1);
    cmp("basic_amax", int'(amax4), 200);
    cmp("basic_amin", int'(amin4), 50);
    tick();
    cmp("basic_bv_after", int'(bv4), 0);

    // Flat window, then WIN=1 single sample.
    do_clr();
    for (int k = 0; k < 4; k++) feed(100);
    cmp("flat_amax", int'(amax4), 100);
    cmp("flat_amin", int'(amin4), 100);
    feed(250);
    cmp("win1_bv", int'(bv1), 1);
    cmp("win1_amax", int'(amax1), 250);
    cmp("win1_amin", int'(amin1), 250);

    // Back-pressure into STALL and exit.
    do_clr();
    band_ready = 1'b0;
    feed(10); feed(20); feed(30); feed(40);
    cmp("bp_first_amax", int'(amax4), 40);
    cmp("bp_first_amin", int'(amin4), 10);
    feed(60); feed(70); feed(80); feed(90);
    cmp("bp_stall_rdy", int'(in_ready4), 0);
    cmp("bp_stall_amax", int'(amax4), 40);
    cmp("bp_stall_amin", int'(amin4), 10);
    band_ready = 1'b1;
    tick();
    cmp("bp_exit_bv", int'(bv4), 1);
    cmp("bp_exit_rdy", int'(in_ready4), 1);
    cmp("bp_exit_amax", int'(amax4), 90);
`ifdef MAXMIN_BAND_STICKY_EN
    cmp("bp_exit_amin", int'(amin4), 10);
`else
    cmp("bp_exit_amin", int'(amin4), 60);
`endif
    tick();
    cmp("bp_drain_bv", int'(bv4), 0);

    // clr discards a partial window and drops its own sample.
    do_clr();
    nbands = 0;
    feed(5); feed(250);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    feed(10); feed(20); feed(30); feed(40);
    tick(); tick();
    cmp("clr_nbands", nbands, 1);
    cmp("clr_amax", lastmax, 40);
    cmp("clr_amin", lastmin, 10);

    // Two consecutive windows: sticky merge versus bare window.
    do_clr();
    feed(100); feed(150); feed(120); feed(130);
    cmp("w1_amax", int'(amax4), 150);
    cmp("w1_amin", int'(amin4), 100);
    feed(50); feed(60); feed(70); feed(80);
`ifdef MAXMIN_BAND_STICKY_EN
    cmp("w2_amax", int'(amax4), 150);
`else
    cmp("w2_amax", int'(amax4), 80);
`endif
    cmp("w2_amin", int'(amin4), 50);

    // Asynchronous reset mid-window while a band is pending.
    do_clr();
    band_ready = 1'b0;
    feed(1); feed(2); feed(3); feed(4); feed(5); feed(6);
    cmp("pre_rst_bv", int'(bv4), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    band_ready = 1'b1;
    feed(7); feed(3); feed(9); feed(1);
    cmp("post_rst_amax", int'(amax4), 9);
    cmp("post_rst_amin", int'(amin4), 1);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom_range(0, 255));
      band_ready = ($urandom_range(0, 2) != 0);
      clr        = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 1'b0; clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
